// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of the encoder.
// The bundle source drives through master; the encoder sits on slave.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Cond;
   logic [1:0]  Op;
   logic [5:0]  Funct;
   logic [3:0]  Rn;
   logic [3:0]  Rd;
   logic [11:0] Src2;
   logic [23:0] Imm24;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;

   // in_valid/in_ready: a bundle moves on a rising edge where both are 1; the
   // source holds every field stable while in_valid=1 and in_ready=0.
   modport master (
      output in_valid, Cond, Op, Funct, Rn, Rd, Src2, Imm24,
      input  in_ready, mem_we, mem_addr, mem_wd
   );

   modport slave (
      input  in_valid, Cond, Op, Funct, Rn, Rd, Src2, Imm24,
      output in_ready, mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/instr_encoder.sv
// ARM-subset instruction encoder: checks decoded field bundles, packs legal ones
// into 32-bit words and writes them to instruction memory at consecutive words.
module instr_encoder #(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   localparam int         CW        = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   instr_encoder_if.slave bus,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          busy,
   output logic          err,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t      state;
   logic        legal;
   logic        xfer;
   logic [31:0] word;

   assign full         = (count == CW'(DEPTH));
   assign busy         = (state == RUN);
   assign bus.in_ready = (state == RUN) & ~full & ~start;
   assign xfer         = bus.in_valid & bus.in_ready;
   assign state_dbg    = state;

   always_comb begin
      legal = 1'b0;
      case (bus.Op)
         2'b00: begin
            case (bus.Funct[4:1])
               4'b0100, 4'b0101, 4'b0010, 4'b0000, 4'b1100,
               4'b1000, 4'b1001, 4'b1010, 4'b1011: legal = 1'b1;
               default:                            legal = 1'b0;
            endcase
            // Vector opcodes (Funct[4:3]=10) are only defined with Funct[5] set.
            if (bus.Funct[4:3] == 2'b10 && !bus.Funct[5]) legal = 1'b0;
         end
         2'b01:   legal = 1'b1;
         2'b10:   legal = bus.Funct[5];
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      word = {bus.Cond, bus.Op, bus.Funct, bus.Rn, bus.Rd, bus.Src2};
      if (bus.Op == 2'b10) word = {bus.Cond, 2'b10, bus.Funct[5:4], bus.Imm24};
   end

   // count doubles as the write pointer: both advance only on legal words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         count        <= '0;
         err          <= 1'b0;
         bus.mem_we   <= 1'b0;
         bus.mem_addr <= BASE_ADDR;
         bus.mem_wd   <= 32'h0;
      end else begin
         bus.mem_we <= 1'b0;
         if (start) begin
            state <= RUN;
            count <= '0;
            err   <= 1'b0;
         end else if (xfer) begin
            if (legal) begin
               bus.mem_we   <= 1'b1;
               bus.mem_addr <= BASE_ADDR + (32'(count) << 2);
               bus.mem_wd   <= word;
               count        <= count + 1'b1;
               if (count == CW'(DEPTH - 1)) state <= FULL;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential ARM-subset instruction encoder and program writer. It accepts decoded instruction fields over a valid/ready handshake and checks them against the control classes our decoder supports: data-processing, floating-point, vector, memory and branch. Each legal instruction is packed into a 32-bit word and written into instruction memory at consecutive word addresses. It sits between the test/boot program source and the instruction memory, producing exactly the words the single-cycle datapath decodes.

## Interface
- DEPTH, 64: maximum number of words written per session.
- BASE_ADDR, 32'h0: byte address of the first word written.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; opens a new session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- Cond  in  4  condition field.
- Op  in  2  instruction class.
- Funct  in  6  function field.
- Rn  in  4  first source register.
- Rd  in  4  destination register.
- Src2  in  12  operand-2 field, used when Op=00/01.
- Imm24  in  24  branch offset, used when Op=10.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  write byte address.
- mem_wd  out  32  write data.
- count  out  $clog2(DEPTH+1)  legal words written in the current session.
- full  out  1  count==DEPTH.
- busy  out  1  session open (state RUN).
- err  out  1  sticky flag: an illegal bundle was dropped.

## Operation
- FSM states: IDLE, RUN, FULL.
  - IDLE→RUN on start.
  - RUN→FULL on the edge where count becomes DEPTH.
  - FULL→RUN on start.
  - RUN→RUN on start (re-arm).
- On start:
  - The write pointer returns to 0 and count clears to 0.
  - err clears.
- Handshake:
  - in_ready = (state==RUN) & ~full & ~start.
  - A transfer occurs on a rising edge where in_valid & in_ready.
  - Fields must be held stable while in_valid=1 and in_ready=0.
- Legality checks:
  - Op=00: Funct[4:1] ∈ {0100, 0101, 0010, 0000, 1100, 1000, 1001, 1010, 1011}. In addition, Funct[4:3]=10 (vector) requires Funct[5]=1.
  - Op=01: always legal.
  - Op=10: requires Funct[5]=1.
  - Op=11: illegal.
- Encoding:
  - Op=00/01: {Cond, Op, Funct, Rn, Rd, Src2}.
  - Op=10: {Cond, 2'b10, Funct[5:4], Imm24}.
- Legal transfer:
  - mem_addr = BASE_ADDR + 4·ptr, and mem_wd takes the encoded word.
  - ptr and count each increment by 1.
- Illegal transfer:
  - The handshake still completes.
  - No write occurs; ptr and count are unchanged.
  - err is set and stays set until start or reset.
- Address arithmetic: 32-bit, BASE_ADDR + {ptr, 2'b00}; no wrap, because ptr never exceeds DEPTH-1 at a write.

## Timing
- Reset values:
  - State IDLE; in_ready=0.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wd=0.
  - count=0, full=0, busy=0, err=0.
- Latency: a transfer on edge E gives mem_we=1, with mem_addr and mem_wd valid, for exactly the cycle after E.
- count and full update at E.
- Throughput: one bundle per cycle. Back-to-back transfers give consecutive mem_we cycles at consecutive addresses.
- mem_we deasserts in the cycle after any edge without a legal transfer.
- Simultaneous events:
  - start with in_valid: no transfer, because start forces in_ready=0. Start wins.
  - start on the edge after a transfer: that transfer's write still issues at the old address. The next accepted word goes to BASE_ADDR.
  - Last slot: the transfer that makes count==DEPTH is written. in_ready=0 from the following cycle.
- Reset asserted mid-session: all outputs take their reset values immediately, asynchronously. Any write not yet issued is lost. After reset deasserts, the FSM stays in IDLE until start.

## Test plan
- Reset, start, then bundle Cond=1110, Op=00, Funct=101000, Rn=2, Rd=1, Src2=0x005 → next cycle mem_we=1, mem_addr=BASE_ADDR, mem_wd=0xE2821005; count=1.
- Branch bundle Cond=1110, Op=10, Funct=100000, Imm24=0xFFFFFE → mem_wd=0xEAFFFFFE, written at BASE_ADDR+4.
- Illegal vector bundle with Op=00, Funct=010000, then bundle Op=00, Funct=110000, Rn=3, Rd=4, Src2=0x005:
  - After the first bundle: err=1, no mem_we, count unchanged.
  - The second bundle is written as 0xE3034005 at the next free address.
- Op=11 bundle → err=1, no write. A following start clears err to 0.
- DEPTH=4, five back-to-back valid bundles:
  - Writes occur at offsets 0x0, 0x4, 0x8, 0xC.
  - full=1 and in_ready=0 after the fourth transfer; the fifth bundle is held.
  - A start then accepts the fifth bundle at BASE_ADDR.
- start asserted with in_valid=1 → no transfer that cycle. Assert reset mid-session → outputs go to reset values at once and busy=0 until the next start.
